inst_loader: RTL and testbench
==============================

// Module: inst_loader
// PURPOSE
//  Boot-time instruction loader upstream of the processor's instruction memory.
//  Takes a serial byte stream (UART Rx), packs bytes little-endian into 32-bit words,
//  writes them to sequential byte addresses 0,4,8,... of the instruction memory.
//  Holds the processor in reset while loading and releases it on successful completion.
// PARAMETERS
//  ADDR_WIDTH  16    instruction-memory byte-address width
//  DATA_WIDTH  32    instruction word width (must be 32)
//  MAX_WORDS   1024  largest accepted program, in words; must be <= 2**(ADDR_WIDTH-2)
// PORTS
//  clk          in   1           system clock; all state changes on rising edge
//  rst          in   1           asynchronous, active-high reset
//  load_req     in   1           1-cycle pulse: abort any state and restart in IDLE
//  rx_data      in   8           received byte
//  rx_valid     in   1           rx_data is valid this cycle; each high cycle = one byte
//  imem_we      out  1           instruction-memory write strobe, 1 cycle per word
//  imem_addr    out  ADDR_WIDTH  byte address of the word written (word_idx*4)
//  imem_wdata   out  DATA_WIDTH  packed word; byte0 -> [7:0], byte3 -> [31:24]
//  cpu_rst      out  1           processor reset; high unless state is DONE
//  busy         out  1           high in HDR0, HDR1, PAYLOAD (and CSUM)
//  done         out  1           high in DONE
//  err          out  1           high in ERROR
//  word_cnt     out  ADDR_WIDTH-2  words written so far
// BEHAVIOUR
//  Reset values: imem_we=0, imem_addr=0, imem_wdata=0, cpu_rst=1, busy=0, done=0,
//   err=0, word_cnt=0; state=IDLE. Reset mid-load discards partial word and count.
//  Stream format: N_lo, N_hi (16-bit word count N), then 4*N payload bytes.
//  FSM: IDLE -(rx_valid)-> HDR1 taking byte as N_lo (IDLE acts as HDR0).
//   HDR1 -(rx_valid)-> N_hi captured; N==0 -> DONE; N>MAX_WORDS -> ERROR; else PAYLOAD.
//   PAYLOAD: byte counter 0..3 packs bytes; on 4th byte, next cycle imem_we=1 with
//    imem_addr=word_cnt*4, imem_wdata=packed word; word_cnt increments same edge.
//    After word N is written -> DONE (or CSUM when checksum enabled).
//   DONE: cpu_rst=0 from the cycle after entry; rx_valid ignored.
//   ERROR: cpu_rst=1, err=1; rx_valid ignored.
//  load_req has priority over rx_valid in the same cycle; it clears word_cnt, byte
//   counter, err, done and asserts cpu_rst on the next edge; the byte is dropped.
//  Latency: imem_we registered, exactly 1 cycle after the rx_valid of byte 3 of a word.
//  Back-to-back rx_valid every cycle is supported with no byte loss.
//  imem_addr/imem_wdata hold their last value when imem_we=0.
//  No address wrap: MAX_WORDS check in HDR1 bounds word_cnt.
// CONFIGURATION
//  INST_LOADER_CHECKSUM_EN defined: after payload, state CSUM accepts one byte; it must
//   equal XOR of all 4*N payload bytes (N=0: must be 0x00). Match -> DONE, else ERROR.
//   Running XOR cleared on reset/load_req.
//  Not defined: no CSUM state; last payload word goes straight to DONE.
// STRUCTURE
//  Package inst_loader_pkg: state enum (IDLE, HDR1, PAYLOAD, CSUM, DONE, ERROR),
//   HDR_BYTES=2, BYTES_PER_WORD=4.
//  Sub-module word_packer: byte shift/pack register + 2-bit byte counter, outputs
//   word_valid pulse and word; cleared by rst or load_req. FSM stays in inst_loader.
// TESTING
//  1. rst, stream 02 00 13 00 00 00 93 00 10 00 -> imem_we at addr 0x0000 data
//     0x00000013, then addr 0x0004 data 0x00100093; done=1, cpu_rst=0, word_cnt=2.
//  2. stream 00 00 -> done=1, no imem_we pulse, cpu_rst=0 (no-checksum build).
//  3. N=MAX_WORDS+1 header -> err=1, cpu_rst=1, later payload bytes write nothing.
//  4. rst asserted after 6 payload bytes -> all outputs at reset values; reload of
//     full stream writes from addr 0 and completes normally.
//  5. load_req same cycle as rx_valid in DONE -> byte dropped, cpu_rst=1, busy=0,
//     word_cnt=0; fresh stream then loads correctly.
//  6. CHECKSUM_EN: stream 01 00 11 22 33 44 then 44 -> done=1; with 45 -> err=1.

Source files
------------

// File: rtl/inst_loader_pkg.sv
// Purpose: shared types and constants for the boot-time instruction loader.
//   state_t         : loader FSM states (IDLE doubles as the first header byte)
//   HDR_BYTES       : length of the word-count header
//   BYTES_PER_WORD  : bytes packed into one instruction word
package inst_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR1,
    PAYLOAD,
    CSUM,
    DONE,
    ERROR
  } state_t;

  localparam int unsigned HDR_BYTES      = 2;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = BYTES_PER_WORD * BYTE_W;
  localparam int unsigned CNT_W          = $clog2(BYTES_PER_WORD);
  localparam int unsigned SHREG_W        = (BYTES_PER_WORD - 1) * BYTE_W;
  localparam int unsigned HDR_W          = HDR_BYTES * BYTE_W;

endpackage

// File: rtl/inst_loader_word_packer.sv
// Purpose: packs a byte stream little-endian into 32-bit words.
// Ports:
//   i_clk, i_rst      clock, async active-high reset
//   i_clr             synchronous clear of partial word and byte counter
//   i_valid, i_byte   one byte accepted per high cycle
//   o_word_valid_c    combinational: high in the cycle the 4th byte is presented
//   o_word_c          combinational: completed word (byte0 in [7:0])
module inst_loader_word_packer
  import inst_loader_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clr,
  input  logic              i_valid,
  input  logic [BYTE_W-1:0] i_byte,
  output logic              o_word_valid_c,
  output logic [WORD_W-1:0] o_word_c
);

  logic [CNT_W-1:0]   r_cnt;
  logic [SHREG_W-1:0] r_shreg;

  // Shift right so the first byte ends up in the least significant lane.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_shreg <= '0;
    end else if (i_clr) begin
      r_cnt   <= '0;
      r_shreg <= '0;
    end else if (i_valid) begin
      r_cnt   <= r_cnt + CNT_W'(1);
      r_shreg <= {i_byte, r_shreg[SHREG_W-1:BYTE_W]};
    end
  end

  // Word completes with the incoming byte so the caller can register it in one edge.
  assign o_word_valid_c = i_valid && (r_cnt == CNT_W'(BYTES_PER_WORD - 1));
  assign o_word_c       = {i_byte, r_shreg};

endmodule

// File: rtl/inst_loader.sv
// Purpose: boot-time instruction loader. Receives a byte stream
//   (N_lo, N_hi, 4*N payload bytes), writes little-endian words to
//   instruction-memory byte addresses 0,4,8,... and holds the CPU in
//   reset until the load completes.
// Optional feature: define INST_LOADER_CHECKSUM_EN to require a trailing
//   XOR checksum byte over the payload before DONE.
// Ports:
//   clk, rst                 clock, async active-high reset
//   load_req                 restart pulse, has priority over rx_valid
//   rx_data, rx_valid        incoming byte stream
//   imem_we/addr/wdata       instruction-memory write port (registered)
//   cpu_rst                  processor reset, released only in DONE
//   busy, done, err          status
//   word_cnt                 words written so far
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_WORDS  = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_req,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0] imem_wdata,
  output logic                  cpu_rst,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH-3:0] word_cnt
);

  localparam int unsigned WC_W = ADDR_WIDTH - 2;

  state_t            r_state;
  logic [BYTE_W-1:0] r_n_lo;
  logic [HDR_W-1:0]  r_n;
`ifdef INST_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] r_csum;
`endif

  logic              w_pack_valid;
  logic              w_word_valid;
  logic [WORD_W-1:0] w_word;
  logic [HDR_W-1:0]  w_n;
  logic              w_last_word;

  // Only payload bytes reach the packer; a load_req byte is dropped.
  assign w_pack_valid = rx_valid && !load_req && (r_state == PAYLOAD);
  assign w_n          = {rx_data, r_n_lo};
  assign w_last_word  = (32'(word_cnt) + 32'd1) == 32'(r_n);

  inst_loader_word_packer u_packer (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_clr          (load_req),
    .i_valid        (w_pack_valid),
    .i_byte         (rx_data),
    .o_word_valid_c (w_word_valid),
    .o_word_c       (w_word)
  );

  // Loader FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_n_lo     <= '0;
      r_n        <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_rst    <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      word_cnt   <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
      r_csum     <= '0;
`endif
    end else if (load_req) begin
      r_state  <= IDLE;
      imem_we  <= 1'b0;
      cpu_rst  <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      word_cnt <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
      r_csum   <= '0;
`endif
    end else begin
      imem_we <= 1'b0;
      case (r_state)
        IDLE: begin
          if (rx_valid) begin
            r_n_lo  <= rx_data;
            busy    <= 1'b1;
            r_state <= HDR1;
          end
        end

        HDR1: begin
          if (rx_valid) begin
            r_n <= w_n;
            if (w_n == '0) begin
`ifdef INST_LOADER_CHECKSUM_EN
              r_state <= CSUM;
`else
              r_state <= DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
`endif
            end else if (32'(w_n) > 32'(MAX_WORDS)) begin
              r_state <= ERROR;
              busy    <= 1'b0;
              err     <= 1'b1;
            end else begin
              r_state <= PAYLOAD;
            end
          end
        end

        PAYLOAD: begin
`ifdef INST_LOADER_CHECKSUM_EN
          if (rx_valid) r_csum <= r_csum ^ rx_data;
`endif
          if (w_word_valid) begin
            imem_we    <= 1'b1;
            imem_addr  <= {word_cnt, 2'b00};
            imem_wdata <= DATA_WIDTH'(w_word);
            word_cnt   <= word_cnt + WC_W'(1);
            if (w_last_word) begin
`ifdef INST_LOADER_CHECKSUM_EN
              r_state <= CSUM;
`else
              r_state <= DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
`endif
            end
          end
        end

`ifdef INST_LOADER_CHECKSUM_EN
        CSUM: begin
          if (rx_valid) begin
            busy <= 1'b0;
            if (rx_data == r_csum) begin
              r_state <= DONE;
              done    <= 1'b1;
            end else begin
              r_state <= ERROR;
              err     <= 1'b1;
            end
          end
        end
`endif

        // Release the CPU one cycle after entry so the final write has landed.
        DONE: cpu_rst <= 1'b0;

        ERROR: cpu_rst <= 1'b1;

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Purpose: self-checking bench for inst_loader. Expected memory writes are
//   queued as stimulus is driven and compared as the DUT issues them.
module tb_inst_loader;

  localparam int unsigned AW   = 16;
  localparam int unsigned DW   = 32;
  localparam int unsigned MAXW = 1024;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_req = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_wdata;
  logic          cpu_rst;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW-3:0] word_cnt;

  wr_t         exp_q[$];
  logic [31:0] prog[$];
  int          n_assert = 0;
  int          n_fail   = 0;

  inst_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WORDS(MAXW)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_req   (load_req),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_rst    (cpu_rst),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .word_cnt   (word_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_we", 32'(imem_we), 32'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(imem_addr), 32'(e.addr));
        check("wr_data", imem_wdata, e.data);
      end
    end
  end

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_load_req();
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  // Sends header + all words of prog back-to-back (plus checksum when enabled).
  task automatic run_prog();
    logic [7:0]  x;
    logic [15:0] n;
    x = 8'h00;
    n = 16'(prog.size());
    send(n[7:0]);
    send(n[15:8]);
    for (int i = 0; i < prog.size(); i++) begin
      exp_q.push_back('{addr: AW'(i * 4), data: prog[i]});
      for (int k = 0; k < 4; k++) begin
        logic [31:0] w;
        logic [7:0]  b;
        w = prog[i];
        b = w[8*k +: 8];
        x = x ^ b;
        send(b);
      end
    end
`ifdef INST_LOADER_CHECKSUM_EN
    send(x);
`endif
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_we"},    32'(imem_we),    32'd0);
    check({tag, "_addr"},  32'(imem_addr),  32'd0);
    check({tag, "_wdata"}, imem_wdata,      32'd0);
    check({tag, "_cpurst"},32'(cpu_rst),    32'd1);
    check({tag, "_busy"},  32'(busy),       32'd0);
    check({tag, "_done"},  32'(done),       32'd0);
    check({tag, "_err"},   32'(err),        32'd0);
    check({tag, "_wcnt"},  32'(word_cnt),   32'd0);
  endtask

  task automatic check_done(input string tag, input int n);
    check({tag, "_done"},   32'(done),     32'd1);
    check({tag, "_err"},    32'(err),      32'd0);
    check({tag, "_busy"},   32'(busy),     32'd0);
    check({tag, "_cpurst"}, 32'(cpu_rst),  32'd0);
    check({tag, "_wcnt"},   32'(word_cnt), 32'(n));
    check({tag, "_drain"},  32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    // Reset values
    @(negedge clk);
    check_reset_vals("rst");
    rst = 1'b0;
    @(negedge clk);

    // 1: two-word program
    prog = '{32'h00000013, 32'h00100093};
    run_prog();
    settle();
    check_done("t1", 2);

    // 2: empty program
    pulse_load_req();
    prog.delete();
    run_prog();
    settle();
    check_done("t2", 0);

    // 3: oversize header, later bytes write nothing
    pulse_load_req();
    send(8'(MAXW + 1));
    send(8'((MAXW + 1) >> 8));
    settle();
    check("t3_err",    32'(err),     32'd1);
    check("t3_cpurst", 32'(cpu_rst), 32'd1);
    check("t3_busy",   32'(busy),    32'd0);
    for (int i = 0; i < 8; i++) send(8'(i + 1));
    settle();
    check("t3_err2",  32'(err),      32'd1);
    check("t3_done",  32'(done),     32'd0);
    check("t3_wcnt",  32'(word_cnt), 32'd0);

    // 4: reset after 6 payload bytes, then full reload
    pulse_load_req();
    send(8'h02); send(8'h00);
    exp_q.push_back('{addr: AW'(0), data: 32'hDDCCBBAA});
    send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
    send(8'h11); send(8'h22);
    rst = 1'b1;
    #1;
    check_reset_vals("t4_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    prog = '{32'hCAFEF00D, 32'h12345678};
    run_prog();
    settle();
    check_done("t4", 2);

    // 5: load_req collides with a byte in DONE
    rx_data  = 8'h05;
    rx_valid = 1'b1;
    load_req = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    load_req = 1'b0;
    check("t5_cpurst", 32'(cpu_rst),  32'd1);
    check("t5_busy",   32'(busy),     32'd0);
    check("t5_wcnt",   32'(word_cnt), 32'd0);
    check("t5_done",   32'(done),     32'd0);
    prog = '{32'h00500093, 32'h00A00113, 32'h002081B3};
    run_prog();
    settle();
    check_done("t5", 3);

    // Largest accepted program
    pulse_load_req();
    prog.delete();
    for (int i = 0; i < int'(MAXW); i++) prog.push_back($urandom());
    run_prog();
    settle();
    check_done("tmax", int'(MAXW));

`ifdef INST_LOADER_CHECKSUM_EN
    // 6: checksum match and mismatch
    pulse_load_req();
    exp_q.push_back('{addr: AW'(0), data: 32'h44332211});
    send(8'h01); send(8'h00);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    send(8'h44);
    settle();
    check_done("t6a", 1);
    pulse_load_req();
    exp_q.push_back('{addr: AW'(0), data: 32'h44332211});
    send(8'h01); send(8'h00);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    send(8'h45);
    settle();
    check("t6b_err",    32'(err),     32'd1);
    check("t6b_done",   32'(done),    32'd0);
    check("t6b_cpurst", 32'(cpu_rst), 32'd1);
    check("t6b_drain",  32'(exp_q.size()), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
